vga_fetch: RTL and testbench

VGA_FETCH -- requirements
Module: vga_fetch

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_fifo.sv | 80 ++++++++
 rtl/vga_fetch.sv | 114 +++++++++++
 tb/tb_vga_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame fetch path: bus widths, default
// frame geometry and the fetch FSM state encoding.
package vga_pkg;

  localparam int VGA_ADDR_W      = 15;
  localparam int VGA_DATA_W      = 8;
  localparam int VGA_FRAME_W     = 160;
  localparam int VGA_FRAME_H     = 120;
  localparam int VGA_FRAME_WORDS = VGA_FRAME_W * VGA_FRAME_H;
  localparam int VGA_FIFO_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } vga_state_t;

endpackage

// File: rtl/vga_fifo.sv
// Pixel prefetch FIFO. The head byte is kept in a register (rdata) so the
// VGA stage sees a clean registered output; flush empties it in one edge.
module vga_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = VGA_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [VGA_DATA_W-1:0] wdata,
  input  logic                  rd,
  output logic [VGA_DATA_W-1:0] rdata,
  output logic                  valid,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [VGA_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_inc;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count_next;
  logic [VGA_DATA_W-1:0] head_next;

  // flush wins over any simultaneous write or read
  assign push       = wr & ~flush;
  assign pop        = rd & (count != '0) & ~flush;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign valid      = (count != '0);

  // storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // next head: bypass the incoming byte when it becomes the head, else hold
  always_comb begin
    head_next = rdata;
    if (count == '0) begin
      if (push) head_next = wdata;
    end else if (pop) begin
      if (count == CNT_W'(1)) begin
        if (push) head_next = wdata;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count <= count_next;
    end
  end

  // registered head byte, held when the FIFO runs empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else        rdata <= head_next;
  end

endmodule

// File: rtl/vga_fetch.sv
// Frame fetch engine: streams one frame of pixel bytes from video memory
// into the prefetch FIFO, throttled by FIFO occupancy, restarted at vsync.
//
//  state | meaning
//  IDLE  | no frame started since reset, no requests
//  FETCH | mem_req high, waiting for mem_ack on mem_addr
//  HOLD  | FIFO full, request paused until a slot frees up
//  DONE  | whole frame fetched, FIFO draining
module vga_fetch
  import vga_pkg::*;
#(
  parameter logic [VGA_ADDR_W-1:0] BASE_ADDR   = 15'h0000,
  parameter int                    FRAME_WORDS = VGA_FRAME_WORDS,
  parameter int                    FIFO_DEPTH  = VGA_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  output logic                  mem_req,
  output logic [VGA_ADDR_W-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [VGA_DATA_W-1:0] mem_data,
  input  logic                  pix_rd,
  output logic [VGA_DATA_W-1:0] pix_data,
  output logic                  pix_valid,
  output logic                  underflow
);

  localparam int                    CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [VGA_ADDR_W-1:0] LAST_WORD = VGA_ADDR_W'(FRAME_WORDS - 1);

  vga_state_t            state;
  vga_state_t            state_next;
  logic [VGA_ADDR_W-1:0] word_cnt;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_wr;
  logic                  fifo_full;
  logic                  last_word;
  logic                  will_fill;

  // an ack coinciding with frame_start belongs to the old frame and is dropped
  assign fifo_wr   = (state == ST_FETCH) & mem_ack & ~frame_start;
  assign last_word = (word_cnt == LAST_WORD);
  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
  // this ack takes the last free slot unless a pop happens in the same cycle
  assign will_fill = (fifo_count == CNT_W'(FIFO_DEPTH - 1)) & ~pix_rd;

  // state register; async reset drops mem_req immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // next-state logic, frame_start restarts from any state
  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = ST_FETCH;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_FETCH: begin
          if (mem_ack && last_word)      state_next = ST_DONE;
          else if (mem_ack && will_fill) state_next = ST_HOLD;
        end
        ST_HOLD:  if (!fifo_full) state_next = ST_FETCH;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    mem_req = (state == ST_FETCH);
  end

  // address and word counter; counter saturates at the last word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= BASE_ADDR;
      word_cnt <= '0;
    end else if (frame_start) begin
      mem_addr <= BASE_ADDR;
      word_cnt <= '0;
    end else if (fifo_wr) begin
      mem_addr <= mem_addr + VGA_ADDR_W'(1);
      if (!last_word) word_cnt <= word_cnt + VGA_ADDR_W'(1);
    end
  end

  // sticky underflow, cleared only by a new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     underflow <= 1'b0;
    else if (frame_start)           underflow <= 1'b0;
    else if (pix_rd && !pix_valid)  underflow <= 1'b1;
  end

  vga_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .wr    (fifo_wr),
    .wdata (mem_data),
    .rd    (pix_rd),
    .rdata (pix_data),
    .valid (pix_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_vga_fetch.sv
// Self-checking bench for vga_fetch: reset values, a vector table for the
// initial fill, hand sequences for throttling, end of frame, restart,
// underflow and async reset, then random traffic against a queue model.
module tb_vga_fetch;

  localparam int          N    = 16;
  localparam int          D    = 8;
  localparam logic [14:0] BASE = 15'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        mem_ack = 1'b0;
  logic        pix_rd = 1'b0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        underflow;

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input logic [14:0] a);
    return 8'(a[7:0] * 8'd7) + 8'h31;
  endfunction

  assign mem_data = byte_of(mem_addr);

  vga_fetch #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (N),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow)
  );

  int errors = 0;
  int checks = 0;

  // reference model: FIFO contents as a byte queue plus frame progress
  logic [7:0] q[$];
  int         fetched;
  bit         active;
  bit         m_uf;
  bit         prev_fs;
  int         prev_size;
  logic [7:0] m_pd;
  int         accepts = 0;
  int         max_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // a request is outstanding while the frame is unfinished and the FIFO has
  // had room for a full cycle (or the frame was just restarted)
  function automatic bit pred_req();
    return active && (fetched < N) && (q.size() < D) && ((prev_size < D) || prev_fs);
  endfunction

  task automatic model_reset();
    q.delete();
    fetched   = 0;
    active    = 1'b0;
    m_uf      = 1'b0;
    prev_fs   = 1'b0;
    prev_size = 0;
    m_pd      = 8'h00;
  endtask

  task automatic model_check();
    chk("mem_req", 32'(mem_req), 32'(pred_req()));
    if (pred_req()) chk("mem_addr", 32'(mem_addr), 32'(BASE) + 32'(fetched));
    chk("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
    chk("pix_data", 32'(pix_data), 32'(m_pd));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  task automatic model_update(input bit fs, input bit ack, input bit rd, input bit req);
    prev_size = q.size();
    prev_fs   = fs;
    if (fs) begin
      q.delete();
      fetched = 0;
      active  = 1'b1;
      m_uf    = 1'b0;
    end else begin
      if (rd) begin
        if (q.size() == 0) m_uf = 1'b1;
        else void'(q.pop_front());
      end
      if (req && ack) begin
        q.push_back(byte_of(BASE + 15'(fetched)));
        fetched++;
      end
      if (q.size() != 0) m_pd = q[0];
    end
  endtask

  // one clock cycle: entered and left at a falling edge
  task automatic step(input bit fs, input bit ack, input bit rd);
    bit req;
    bit acc;
    req = pred_req();
    model_check();
    frame_start = fs;
    mem_ack     = ack;
    pix_rd      = rd;
    acc = mem_req && ack;
    if (acc) begin
      accepts++;
      if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end
    @(posedge clk);
    model_update(fs, ack, rd, req);
    @(negedge clk);
  endtask

  typedef struct {
    bit          fs;
    bit          ack;
    bit          rd;
    bit          e_req;
    logic [14:0] e_addr;
    bit          e_valid;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int acc0;
    int rd_thr;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd1, 1'b1, 8'h31};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd2, 1'b1, 8'h31};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd3, 1'b1, 8'h31};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd4, 1'b1, 8'h31};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd5, 1'b1, 8'h31};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd6, 1'b1, 8'h31};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd7, 1'b1, 8'h31};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 15'd0, 1'b1, 8'h31};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'd0, 1'b1, 8'h31};

    model_reset();

    // values while reset is held
    #23;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'h00);
    chk("rst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    // initial fill with acks every cycle and no reads
    for (int i = 0; i < 11; i++) begin
      chk("tbl_req", 32'(mem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].e_addr));
      chk("tbl_valid", 32'(pix_valid), 32'(tbl[i].e_valid));
      chk("tbl_data", 32'(pix_data), 32'(tbl[i].e_data));
      step(tbl[i].fs, tbl[i].ack, tbl[i].rd);
    end
    chk("fill_accepts", 32'(accepts), 32'd8);
    chk("fill_max_addr", 32'(max_addr), 32'd7);

    // one pop every 4 cycles refills exactly one entry per pop
    acc0 = accepts;
    for (int p = 0; p < 8; p++) begin
      step(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    end
    chk("throttle_accepts", 32'(accepts - acc0), 32'd8);

    // drain to empty and keep reading: end of frame, then underflow
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b1);
    chk("eof_accepts", 32'(accepts), 32'(N));
    chk("eof_max_addr", 32'(max_addr), 32'(N - 1));
    chk("eof_valid", 32'(pix_valid), 32'd0);
    chk("eof_underflow", 32'(underflow), 32'd1);
    chk("eof_pix_data", 32'(pix_data), 32'(byte_of(15'(N - 1))));
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
    chk("uf_sticky", 32'(underflow), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("uf_cleared", 32'(underflow), 32'd0);

    // restart coincident with an ack at address 5
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
    chk("restart_pre_addr", 32'(mem_addr), 32'd5);
    chk("restart_pre_req", 32'(mem_req), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("restart_valid", 32'(pix_valid), 32'd0);
    chk("restart_addr", 32'(mem_addr), 32'(BASE));
    chk("restart_req", 32'(mem_req), 32'd1);

    // async reset in the middle of a fetch
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    chk("pre_reset_uf", 32'(underflow), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("async_pix_valid", 32'(pix_valid), 32'd0);
    chk("async_pix_data", 32'(pix_data), 32'h00);
    chk("async_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);

    // random traffic against the model
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      rd_thr = (i / 500) * 2 + 1;
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < rd_thr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
